// File: rtl/data_sram_bridge.sv
// data_sram_bridge: single-outstanding SRAM-style bus bridge for the MEM stage.
// Captures a load/store on issue, holds it on the bus until accepted, waits for
// data, then bypasses read data to the pipeline and keeps a copy for stalls.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        MemEnableM,
  input  logic [3:0]  MemWenM,
  input  logic [31:0] MemAddrM,
  input  logic [31:0] TWriteDataM,
  input  logic        ExceptDealM,
  input  logic        StallOtherM,
  output logic [31:0] ReadDataM,
  output logic        StallReqM,
  // bus side
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } busReq_t;

  state_t      state, stateNext;
  busReq_t     req;
  logic [31:0] holdData;
  logic        issue;
  logic        complete;

  // Byte-enable pattern to transfer size; irregular patterns fall back to word.
  function automatic logic [1:0] sizeOf(input logic [3:0] wen);
    case (wen)
      4'b0011, 4'b1100:                   sizeOf = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sizeOf = 2'd0;
      default:                            sizeOf = 2'd2;
    endcase
  endfunction

  // An exception in IDLE suppresses the access entirely; once on the bus the
  // transaction always runs to completion.
  assign issue    = (state == IDLE) && MemEnableM && !ExceptDealM;
  assign complete = ((state == ADDR) && data_addr_ok && data_data_ok) ||
                    ((state == DATA) && data_data_ok);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic; completion goes to HOLD while another stall keeps MEM.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (issue) stateNext = ADDR;
      ADDR: begin
        if (complete)          stateNext = StallOtherM ? HOLD : IDLE;
        else if (data_addr_ok) stateNext = DATA;
      end
      DATA: if (complete)     stateNext = StallOtherM ? HOLD : IDLE;
      HOLD: if (!StallOtherM) stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  // Request fields are captured once on issue so they stay stable on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) req <= '0;
    else if (issue) begin
      req.wr    <= |MemWenM;
      req.size  <= sizeOf(MemWenM);
      req.addr  <= MemAddrM;
      req.wdata <= TWriteDataM;
    end
  end

  // Keep the last returned data for cycles after the completion edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          holdData <= '0;
    else if (complete) holdData <= data_rdata;
  end

  assign data_req   = (state == ADDR);
  assign data_wr    = req.wr;
  assign data_size  = req.size;
  assign data_addr  = req.addr;
  assign data_wdata = req.wdata;

  assign ReadDataM  = complete ? data_rdata : holdData;
  // Reset gating keeps the stall request low even if MemEnableM is high in reset.
  assign StallReqM  = rst && (issue || (((state == ADDR) || (state == DATA)) && !complete));

endmodule
